// File: rtl/kitchen_if.sv
// Stove/chimney signal bundle for the kitchen chimney controller.
// The fan_speed member exists only when KITCHEN_FAN_SPEED_EN is defined.
interface kitchen_if #(
  parameter int CNT_W = 6
);
  logic             stove_state;
  logic             chimney;
  logic             purging;
  logic [CNT_W-1:0] purge_remaining;
`ifdef KITCHEN_FAN_SPEED_EN
  logic [1:0]       fan_speed;

  modport master (output stove_state, input chimney, input purging, input purge_remaining,
                  input fan_speed);
  modport slave  (input stove_state, output chimney, output purging, output purge_remaining,
                  output fan_speed);
`else
  modport master (output stove_state, input chimney, input purging, input purge_remaining);
  modport slave  (input stove_state, output chimney, output purging, output purge_remaining);
`endif
endinterface

// File: rtl/kitchen.sv
// Kitchen chimney controller: fan runs with the stove, then for PURGE_CYCLES after stove-off.
// Optional fan_speed output enabled by defining KITCHEN_FAN_SPEED_EN.
module kitchen #(
  parameter int PURGE_CYCLES = 60,
  parameter int CNT_W        = ($clog2(PURGE_CYCLES + 1) > 1) ? $clog2(PURGE_CYCLES + 1) : 1
) (
  input  logic     clk,
  input  logic     rst,
  kitchen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PURGE = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] PURGE_LOAD = CNT_W'(PURGE_CYCLES);
  localparam bit               NO_PURGE   = (PURGE_CYCLES == 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             chimney_q, chimney_d;
  logic             purging_q, purging_d;
`ifdef KITCHEN_FAN_SPEED_EN
  logic [1:0]       fan_q, fan_d;
`endif

  // Next state, counter and output decode; outputs follow the next state so they land with it.
  always_comb begin
    state_d = IDLE;
    rem_d   = '0;
    case (state_q)
      IDLE: begin
        if (bus.stove_state) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (bus.stove_state) begin
          state_d = RUN;
        end else if (NO_PURGE) begin
          state_d = IDLE;
        end else begin
          state_d = PURGE;
          rem_d   = PURGE_LOAD;
        end
      end
      PURGE: begin
        if (bus.stove_state) begin
          state_d = RUN;
        end else if (rem_q > CNT_W'(1)) begin
          state_d = PURGE;
          rem_d   = rem_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    chimney_d = (state_d == RUN) || (state_d == PURGE);
    purging_d = (state_d == PURGE);
`ifdef KITCHEN_FAN_SPEED_EN
    case (state_d)
      RUN:     fan_d = 2'b11;
      PURGE:   fan_d = 2'b01;
      default: fan_d = 2'b00;
    endcase
`endif
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      chimney_q <= 1'b0;
      purging_q <= 1'b0;
`ifdef KITCHEN_FAN_SPEED_EN
      fan_q     <= 2'b00;
`endif
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      chimney_q <= chimney_d;
      purging_q <= purging_d;
`ifdef KITCHEN_FAN_SPEED_EN
      fan_q     <= fan_d;
`endif
    end
  end

  assign bus.chimney         = chimney_q;
  assign bus.purging         = purging_q;
  assign bus.purge_remaining = rem_q;
`ifdef KITCHEN_FAN_SPEED_EN
  assign bus.fan_speed       = fan_q;
`endif

endmodule

// File: tb/tb_kitchen.sv
// Bench for kitchen: three instances (PURGE_CYCLES 60, 0, 1) against an age-since-stove-on model.
module tb_kitchen;

  localparam int NI        = 3;
  localparam int PC [NI]   = '{60, 0, 1};
  localparam int NEVER     = 1000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stove = 1'b0;
  int   nchecks = 0;
  int   nerr = 0;
  int   age [NI];
  bit   model_valid = 1'b0;

  always #5 clk = ~clk;

  kitchen_if #(.CNT_W(6)) bus0 ();
  kitchen_if #(.CNT_W(1)) bus1 ();
  kitchen_if #(.CNT_W(1)) bus2 ();

  assign bus0.stove_state = stove;
  assign bus1.stove_state = stove;
  assign bus2.stove_state = stove;

  kitchen #(.PURGE_CYCLES(60)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  kitchen #(.PURGE_CYCLES(0))  dut1 (.clk(clk), .rst(rst), .bus(bus1));
  kitchen #(.PURGE_CYCLES(1))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // Model: age = edges since the stove was last sampled on (reset forgets it).
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst)        age[i] <= NEVER;
      else if (stove) age[i] <= 0;
      else if (model_valid && age[i] < NEVER) age[i] <= age[i] + 1;
      else if (!model_valid) age[i] <= NEVER;
    end
    if (rst) model_valid <= 1'b1;
  end

  function automatic int e_chim(int i);
    return (age[i] <= PC[i]) ? 1 : 0;
  endfunction
  function automatic int e_purg(int i);
    return (age[i] >= 1 && age[i] <= PC[i]) ? 1 : 0;
  endfunction
  function automatic int e_rem(int i);
    return (e_purg(i) != 0) ? (PC[i] - age[i] + 1) : 0;
  endfunction
  function automatic int e_fan(int i);
    return (age[i] == 0) ? 3 : ((e_purg(i) != 0) ? 1 : 0);
  endfunction

  task automatic chk(input string name, input int act, input int req);
    nchecks++;
    if (act != req) begin
      nerr++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, req);
    end
  endtask

  task automatic cmp(input int i, input int c, input int p, input int r, input int f);
    chk($sformatf("d%0d.chimney", i), c, e_chim(i));
    chk($sformatf("d%0d.purging", i), p, e_purg(i));
    chk($sformatf("d%0d.purge_remaining", i), r, e_rem(i));
`ifdef KITCHEN_FAN_SPEED_EN
    chk($sformatf("d%0d.fan_speed", i), f, e_fan(i));
`else
    if (f != 0) chk($sformatf("d%0d.fan_absent", i), f, 0);
`endif
  endtask

  // Every-cycle comparison against the model, half a period after the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
`ifdef KITCHEN_FAN_SPEED_EN
      cmp(0, int'(bus0.chimney), int'(bus0.purging), int'(bus0.purge_remaining), int'(bus0.fan_speed));
      cmp(1, int'(bus1.chimney), int'(bus1.purging), int'(bus1.purge_remaining), int'(bus1.fan_speed));
      cmp(2, int'(bus2.chimney), int'(bus2.purging), int'(bus2.purge_remaining), int'(bus2.fan_speed));
`else
      cmp(0, int'(bus0.chimney), int'(bus0.purging), int'(bus0.purge_remaining), 0);
      cmp(1, int'(bus1.chimney), int'(bus1.purging), int'(bus1.purge_remaining), 0);
      cmp(2, int'(bus2.chimney), int'(bus2.purging), int'(bus2.purge_remaining), 0);
`endif
    end
  end

  task automatic step(input logic s, input logic r, input int n);
    for (int k = 0; k < n; k++) begin
      stove = s;
      rst   = r;
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    logic s_rand;
    // 1: reset, then idle for 61 cycles
    step(1'b0, 1'b1, 2);
    chk("lit.reset_chimney", int'(bus0.chimney), 0);
    chk("lit.reset_rem", int'(bus0.purge_remaining), 0);
    step(1'b0, 1'b0, 61);
    chk("lit.idle_chimney", int'(bus0.chimney), 0);

    // 2: stove on for 20 cycles
    step(1'b1, 1'b0, 1);
    chk("lit.run_first_edge", int'(bus0.chimney), 1);
    step(1'b1, 1'b0, 19);
    chk("lit.run_purging", int'(bus0.purging), 0);
`ifdef KITCHEN_FAN_SPEED_EN
    chk("lit.run_fan", int'(bus0.fan_speed), 3);
`endif

    // 3: stove off 90 cycles; run-on lasts exactly 60
    step(1'b0, 1'b0, 1);
    chk("lit.purge_start_rem", int'(bus0.purge_remaining), 60);
    chk("lit.model_start_rem", e_rem(0), 60);
    step(1'b0, 1'b0, 59);
    chk("lit.purge_last_chim", int'(bus0.chimney), 1);
    chk("lit.purge_last_rem", int'(bus0.purge_remaining), 1);
    step(1'b0, 1'b0, 1);
    chk("lit.purge_end_chim", int'(bus0.chimney), 0);
    step(1'b0, 1'b0, 29);
    chk("lit.after_purge_chim", int'(bus0.chimney), 0);

    // 4: 30 cycles into purge, then stove back on
    step(1'b1, 1'b0, 3);
    step(1'b0, 1'b0, 30);
    chk("lit.mid_purge_rem", int'(bus0.purge_remaining), 31);
    chk("lit.model_mid_rem", e_rem(0), 31);
    step(1'b1, 1'b0, 1);
    chk("lit.resume_chim", int'(bus0.chimney), 1);
    chk("lit.resume_rem", int'(bus0.purge_remaining), 0);
    chk("lit.resume_purging", int'(bus0.purging), 0);

    // 5: reset at purge_remaining=25
    step(1'b0, 1'b0, 36);
    chk("lit.pre_reset_rem", int'(bus0.purge_remaining), 25);
    step(1'b0, 1'b1, 1);
    chk("lit.abort_chim", int'(bus0.chimney), 0);
    chk("lit.abort_purging", int'(bus0.purging), 0);
    chk("lit.abort_rem", int'(bus0.purge_remaining), 0);
    step(1'b0, 1'b0, 5);
    chk("lit.abort_stays_idle", int'(bus0.chimney), 0);

    // 6: PURGE_CYCLES=0 and =1 boundaries
    step(1'b1, 1'b0, 5);
    step(1'b0, 1'b0, 1);
    chk("lit.p0_drop", int'(bus1.chimney), 0);
    chk("lit.p1_hold", int'(bus2.chimney), 1);
    chk("lit.p1_rem", int'(bus2.purge_remaining), 1);
    step(1'b0, 1'b0, 1);
    chk("lit.p1_drop", int'(bus2.chimney), 0);

    // single-cycle pulse gets a full purge
    step(1'b1, 1'b0, 1);
    step(1'b0, 1'b0, 60);
    chk("lit.pulse_last", int'(bus0.chimney), 1);
    step(1'b0, 1'b0, 1);
    chk("lit.pulse_end", int'(bus0.chimney), 0);

    // random phase
    s_rand = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 29) == 0) s_rand = ~s_rand;
      step(s_rand, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, 1);
    end
    if ($urandom_range(0, 1) == 0) step(1'b1, 1'b0, 2);
    step(1'b0, 1'b0, 70);
    chk("lit.final_idle", int'(bus0.chimney), 0);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
